b_lut_seq: RTL
==============

B_LUT_SEQ -- requirements
Module: b_lut_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, as the operand and result width; the only legal values are 32 and 64.
REQ-002 The block SHALL have parameter LPC, default 2, as the nibble lanes processed per cycle; LPC SHALL divide NL = XLEN/4.
REQ-003 The block SHALL have port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port g_reset, input, 1 bit: the synchronous, active-high reset.
REQ-005 The block SHALL have port valid, input, 1 bit: request present; operands and op bits are sampled in IDLE.
REQ-006 The block SHALL have port op_lut, input, 1 bit: nibble lookup using the table supplied in the operands.
REQ-007 The block SHALL have port op_lutr, input, 1 bit: nibble lookup using the stored table.
REQ-008 The block SHALL have port op_load, input, 1 bit: write the operand table into the stored table.
REQ-009 The block SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-010 The block SHALL have ports crs1, crs2 and crs3, inputs, XLEN bits each: the lookup indices, the table low half and the table high half respectively.
REQ-011 The block SHALL have port ready, output, 1 bit: one-cycle completion strobe.
REQ-012 The block SHALL have port result, output, XLEN bits: the registered result, valid while ready=1.

Function
REQ-013 Operand table T (64 bits, 16 entries of 4 bits) SHALL be defined as follows: for XLEN=32, T={crs3,crs2}; for XLEN=64, T=crs2 and crs3 is ignored; entry i = T[4i+3:4i].
REQ-014 Lookup SHALL be defined as: result lane k (bits 4k+3:4k) = entry[crs1 lane k] of the selected table, for k=0..NL-1.
REQ-015 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-016 In IDLE with valid=1 and exactly one op bit set, the block SHALL accept the request and register crs1 and the selected table; operand changes after acceptance SHALL have no effect.
REQ-017 An accepted op_lut or op_lutr SHALL move IDLE->BUSY with the lane-group counter set to 0.
REQ-018 Each BUSY cycle SHALL compute lanes g*LPC..g*LPC+LPC-1 into the result register, starting at group 0 = least-significant lanes, then increment g.
REQ-019 After group G-1, where G = NL/LPC, the block SHALL go BUSY->DONE.
REQ-020 Latency for a lookup: acceptance at cycle 0 SHALL give ready=1 in cycle G+1; with G=1 this is cycle 2.
REQ-021 op_load SHALL write the stored table at the acceptance edge, go IDLE->DONE, and give ready=1 in cycle 1 with result=0.
REQ-022 In IDLE, valid=1 with zero or more than one op bit set SHALL go IDLE->DONE with result=0, ready in cycle 1, and the stored table unchanged.
REQ-023 DONE SHALL last exactly one cycle with ready=1, then go DONE->IDLE.
REQ-024 The requester SHALL drop valid in the cycle ready=1; if valid is still high in IDLE, the block SHALL treat it as a new request.
REQ-025 ready SHALL be 0 in every state other than DONE.
REQ-026 result SHALL hold its value outside DONE but is defined only while ready=1; unprocessed lanes are don't-care during BUSY.
REQ-027 flush=1 in any state SHALL force IDLE at the next edge, with ready=0 in that cycle, result cleared to 0, and the stored table retained.
REQ-028 flush SHALL take priority over acceptance; a request with valid=1 and flush=1 in IDLE SHALL be dropped.
REQ-029 The stored table SHALL change only on an accepted op_load.
REQ-030 An op_lutr accepted in the IDLE cycle immediately after a load's DONE SHALL see the new table.

Reset
REQ-031 g_reset=1 at a rising edge SHALL force IDLE, ready=0, result=0, group counter=0 and stored table=0, overriding flush and valid.
REQ-032 Reset asserted mid-BUSY SHALL abandon the operation with no ready pulse.
REQ-033 After reset, op_lutr SHALL return 0 in every lane until a load is performed.

Verification
REQ-034 Scenario 1 (XLEN=32, LPC=2): op_lut, crs3=0xFEDCBA98, crs2=0x76543210, crs1=0x1234ABCD -> ready in cycle 5 only, result=0x1234ABCD.
REQ-035 Scenario 2 (XLEN=32, LPC=2): op_lut, crs3=0x89ABCDEF, crs2=0x01234567, crs1=0x0000000F -> result=0x77777778.
REQ-036 Scenario 3 (XLEN=32, LPC=2): op_load with crs3=0xFEDCBA98, crs2=0x76543210 -> ready in cycle 1, result=0; then op_lutr with crs1=0xCAFEBABE, crs2=crs3=0 -> result=0xCAFEBABE.
REQ-037 Scenario 4 (XLEN=32, LPC=2): valid with op_lut=op_load=1 -> ready in cycle 1, result=0; a following op_lutr with crs1=0x11111111 returns the previous stored-table result, showing the table unchanged.
REQ-038 Scenario 5 (XLEN=32, LPC=2): flush in cycle 2 of a lookup -> no ready pulse, IDLE in cycle 3, result=0; the next op_lut completes with correct data and latency.
REQ-039 Scenario 6 (XLEN=64, LPC=16): op_lut, crs2=0xFEDCBA9876543210, crs1=0x0123456789ABCDEF -> ready in cycle 2, result=0x0123456789ABCDEF; reset asserted in cycle 1 of a repeat of this request -> no ready pulse, and all outputs are 0.

Source files
------------

// File: rtl/b_lut_seq.sv
// b_lut_seq: multi-cycle nibble lookup unit.
//
// Each 4-bit lane of crs1 indexes a 16-entry x 4-bit table. The table is either
// taken from the operands (op_lut) or from an internal stored table (op_lutr).
// op_load writes the operand table into the stored table. LPC lanes are
// resolved per BUSY cycle, least-significant lanes first.
//
// Handshake: a request is taken when valid=1 while the block is IDLE; operands
// are captured on that edge and ignored afterwards. Completion is a single-cycle
// ready=1 in DONE with result valid only in that cycle. The requester drops
// valid in the ready cycle; valid still high once back in IDLE is a new request.
// flush (and g_reset) abandon any operation without producing a ready pulse.
//
// Ports:
//   g_clk, g_reset          clock, synchronous active-high reset
//   valid                   request present (sampled in IDLE)
//   op_lut, op_lutr, op_load operation select (exactly one must be set)
//   flush                   abort, back to IDLE, result cleared
//   crs1                    lookup indices (XLEN bits)
//   crs2, crs3              table low / high half (XLEN=64 uses crs2 only)
//   ready                   one-cycle completion strobe
//   result                  registered result
//   dbg_state               current FSM state (0=IDLE, 1=BUSY, 2=DONE)
module b_lut_seq #(
  parameter int XLEN = 32,  // 32 or 64
  parameter int LPC  = 2    // lanes per cycle, must divide XLEN/4
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            valid,
  input  logic            op_lut,
  input  logic            op_lutr,
  input  logic            op_load,
  input  logic            flush,
  input  logic [XLEN-1:0] crs1,
  input  logic [XLEN-1:0] crs2,
  input  logic [XLEN-1:0] crs3,
  output logic            ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int NL = XLEN / 4;
  localparam int G  = NL / LPC;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [63:0]     op_tab;      // table formed from the current operands
  logic [63:0]     tab_q;       // table captured for the running lookup
  logic [63:0]     stored_tab;  // table written by op_load
  logic [XLEN-1:0] idx_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] res_next;
  logic [GW-1:0]   grp_q;

  logic one_op;
  logic take_lookup;
  logic take_load;

  // A 32-bit block needs both operand halves for the 64-bit table; a 64-bit
  // block gets the whole table from crs2.
  generate
    if (XLEN == 32) begin : g_tab32
      assign op_tab = {crs3, crs2};
    end else begin : g_tab64
      logic unused_crs3;
      assign op_tab      = crs2[63:0];
      assign unused_crs3 = ^crs3;
    end
  endgenerate

  // Exactly one of the three op bits set.
  assign one_op      = (op_lut ^ op_lutr ^ op_load) & ~(op_lut & op_lutr & op_load);
  assign take_lookup = valid & one_op & (op_lut | op_lutr);
  assign take_load   = valid & one_op & op_load;

  // FSM state register
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_lookup) begin
          state_d = BUSY;
        end else if (valid) begin
          // loads and malformed requests both finish in one cycle
          state_d = DONE;
        end
      end
      BUSY: begin
        if (grp_q == GW'(G - 1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Resolve the lanes of the current group; other lanes keep their value.
  always_comb begin
    res_next = result_q;
    for (int j = 0; j < LPC; j++) begin
      res_next[(int'(grp_q) * LPC + j) * 4 +: 4] =
        tab_q[{idx_q[(int'(grp_q) * LPC + j) * 4 +: 4], 2'b00} +: 4];
    end
  end

  // Datapath registers
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      tab_q      <= '0;
      stored_tab <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      grp_q      <= '0;
    end else if (flush) begin
      result_q <= '0;
      grp_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_lookup) begin
            idx_q <= crs1;
            tab_q <= op_lut ? op_tab : stored_tab;
            grp_q <= '0;
          end else if (take_load) begin
            stored_tab <= op_tab;
            result_q   <= '0;
          end else if (valid) begin
            result_q <= '0;
          end
        end
        BUSY: begin
          result_q <= res_next;
          grp_q    <= (grp_q == GW'(G - 1)) ? '0 : grp_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
